// File: rtl/pg_guard_seq_pkg.sv
// Shared types and constant helpers for the power-gate guard sequencer.
package pg_guard_seq_pkg;

  // Sequencer states: all channels guarded, settle wait, staggered release, fully open.
  typedef enum logic [1:0] {
    StAsleep,
    StWakeWait,
    StRelease,
    StAwake
  } state_e;

  // Ceiling log2 for elaboration-time width calculation; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned value);
    int unsigned w;
    w = clog2(value);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pg_guard_cell.sv
// One guarded channel: guard flop (reset/set to guarded) and the output gate.
module pg_guard_cell (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q,
  output logic guard
);

  logic guard_q;

  // Guard flop: set wins over clear so a sleep request always aborts a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      guard_q <= 1'b1;
    end else if (set) begin
      guard_q <= 1'b1;
    end else if (clr) begin
      guard_q <= 1'b0;
    end
  end

  // Output gate: data passes only when released and enabled, with no added latency.
  always_comb begin
    q = d & ~guard_q & en;
  end

  assign guard = guard_q;

endmodule

// File: rtl/pg_guard_seq.sv
// Power-gate guard sequencer: holds every channel guarded while asleep, then on
// wake waits a settle delay and releases channels one at a time, lowest first.
module pg_guard_seq
  import pg_guard_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned WAKE_CYCLES = 16,
  parameter int unsigned STAGGER     = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SLEEP_REQ,
  input  logic [WIDTH-1:0] CH_EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] GUARD,
  output logic             AWAKE,
  output logic             SLEEP_ACK,
  output logic             BUSY
);

  localparam int unsigned WakeW = cnt_width(WAKE_CYCLES + 1);
  localparam int unsigned StagW = cnt_width(STAGGER);
  localparam int unsigned IdxW  = cnt_width(WIDTH);

  localparam logic [WakeW-1:0] WakeLast = WakeW'(WAKE_CYCLES);
  localparam logic [StagW-1:0] StagLast = StagW'(STAGGER - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(WIDTH - 1);

  state_e            state_q;
  logic [WakeW-1:0]  wake_cnt_q;
  logic [StagW-1:0]  stag_cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic [IdxW-1:0]   idx_next;
  logic              awake_q;
  logic              ack_q;
  logic              busy_q;

  logic              start_rel;
  logic              step_rel;
  logic              done_rel;
  logic [WIDTH-1:0]  guard_clr;

  assign idx_next = idx_q + IdxW'(1);

  // Decode this edge's release events; a pending sleep request suppresses all of them.
  always_comb begin
    start_rel = 1'b0;
    step_rel  = 1'b0;
    done_rel  = 1'b0;
    if (!SLEEP_REQ) begin
      case (state_q)
        StAsleep:   start_rel = (WAKE_CYCLES == 0);
        StWakeWait: start_rel = (wake_cnt_q >= WakeLast);
        StRelease: begin
          if (idx_q == IdxLast) begin
            done_rel = 1'b1;
          end else if (stag_cnt_q == StagLast) begin
            step_rel = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel clear strobes: channel 0 on entry to release, then the next index per slot.
  always_comb begin
    guard_clr = '0;
    if (start_rel) begin
      guard_clr[0] = 1'b1;
    end else if (step_rel) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (idx_next == IdxW'(i)) begin
          guard_clr[i] = 1'b1;
        end
      end
    end
  end

  // Sequencer FSM with counters and registered status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StAsleep;
      wake_cnt_q <= '0;
      stag_cnt_q <= '0;
      idx_q      <= '0;
      awake_q    <= 1'b0;
      ack_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else if (SLEEP_REQ) begin
      // Sleep is honoured from any state at this very edge, aborting any release.
      state_q    <= StAsleep;
      wake_cnt_q <= '0;
      stag_cnt_q <= '0;
      idx_q      <= '0;
      awake_q    <= 1'b0;
      ack_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        StAsleep: begin
          ack_q  <= 1'b0;
          busy_q <= 1'b1;
          if (start_rel) begin
            state_q    <= StRelease;
            idx_q      <= '0;
            stag_cnt_q <= '0;
          end else begin
            // This edge is the first of the settle cycles.
            state_q    <= StWakeWait;
            wake_cnt_q <= WakeW'(1);
          end
        end
        StWakeWait: begin
          if (start_rel) begin
            state_q    <= StRelease;
            wake_cnt_q <= '0;
            idx_q      <= '0;
            stag_cnt_q <= '0;
          end else if (wake_cnt_q != WakeLast) begin
            wake_cnt_q <= wake_cnt_q + WakeW'(1);
          end
        end
        StRelease: begin
          if (done_rel) begin
            state_q    <= StAwake;
            idx_q      <= '0;
            stag_cnt_q <= '0;
            awake_q    <= 1'b1;
            busy_q     <= 1'b0;
          end else if (step_rel) begin
            idx_q      <= idx_next;
            stag_cnt_q <= '0;
          end else begin
            stag_cnt_q <= stag_cnt_q + StagW'(1);
          end
        end
        StAwake: ;
        default: begin
          state_q <= StAsleep;
          awake_q <= 1'b0;
          ack_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign AWAKE     = awake_q;
  assign SLEEP_ACK = ack_q;
  assign BUSY      = busy_q;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    pg_guard_cell u_cell (
      .clk   (CLK),
      .rst   (RST),
      .set   (SLEEP_REQ),
      .clr   (guard_clr[i]),
      .en    (CH_EN[i]),
      .d     (D[i]),
      .q     (Q[i]),
      .guard (GUARD[i])
    );
  end

endmodule

// File: doc/pg_guard_seq.md
PG_GUARD_SEQ -- requirements
Module: pg_guard_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of guarded channels (1..32).
REQ-002 SHALL have parameter WAKE_CYCLES, default 16: settle delay before the first channel release (0..65535).
REQ-003 SHALL have parameter STAGGER, default 1: cycles between successive channel releases (1..255).
REQ-004 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port SLEEP_REQ, input, 1: synchronous level; 1 requests guard of all channels, 0 requests wake.
REQ-007 SHALL have port CH_EN, input, WIDTH: per-channel enable; 0 keeps that channel guarded permanently.
REQ-008 SHALL have port D, input, WIDTH: channel data in.
REQ-009 SHALL have port Q, output, WIDTH: guarded data out.
REQ-010 SHALL have port GUARD, output, WIDTH: registered per-channel guard state; 1 means guarded.
REQ-011 SHALL have port AWAKE, output, 1: high only in state AWAKE.
REQ-012 SHALL have port SLEEP_ACK, output, 1: high only in state ASLEEP.
REQ-013 SHALL have port BUSY, output, 1: high in WAKE_WAIT or RELEASE.

Function
REQ-014 Q[i] SHALL equal D[i] AND NOT GUARD[i] AND CH_EN[i], combinationally, with zero latency from D.
REQ-015 The FSM SHALL have exactly four states: ASLEEP, WAKE_WAIT, RELEASE, AWAKE.
REQ-016 In ASLEEP with SLEEP_REQ=0 at an edge, the block SHALL enter WAKE_WAIT, or RELEASE directly when WAKE_CYCLES=0.
REQ-017 WAKE_WAIT SHALL last exactly WAKE_CYCLES cycles before the block enters RELEASE.
REQ-018 With E0 the edge entering RELEASE, GUARD[i] SHALL clear at edge E0+i*STAGGER, releasing the lowest index first.
REQ-019 A channel with CH_EN[i]=0 SHALL still consume its release slot, so sequence timing is independent of CH_EN.
REQ-020 The block SHALL enter AWAKE at edge E0+(WIDTH-1)*STAGGER+1.
REQ-021 In AWAKE, WAKE_WAIT or RELEASE, SLEEP_REQ=1 at an edge SHALL set GUARD to all ones and enter ASLEEP at that same edge; a partial release is aborted.
REQ-022 In ASLEEP, GUARD SHALL remain all ones while SLEEP_REQ=1.
REQ-023 A SLEEP_REQ pulse of one cycle during AWAKE SHALL cause a complete ASLEEP, WAKE_WAIT, RELEASE sequence.
REQ-024 The wake counter SHALL be clog2(WAKE_CYCLES+1) bits wide, saturate at its terminal value, and never wrap.
REQ-025 The stagger counter SHALL be clog2(STAGGER) bits wide; the channel index counter SHALL be clog2(WIDTH) bits wide.
REQ-026 A change of CH_EN SHALL affect Q immediately and SHALL NOT alter FSM or GUARD state.

Reset
REQ-027 RST=1 SHALL immediately, without CLK, force state ASLEEP, GUARD all ones, Q all zeros, SLEEP_ACK=1, AWAKE=0, BUSY=0, and all counters to 0.
REQ-028 After RST deasserts, the first CLK edge SHALL evaluate SLEEP_REQ according to REQ-016.

Structure
REQ-029 Package pg_guard_seq_pkg SHALL hold the state enum and the clog2 helper constant function.
REQ-030 The per-channel guard flop plus output gate SHALL be the sub-module pg_guard_cell, instantiated WIDTH times.

Verification
All scenarios use WIDTH=4, WAKE_CYCLES=3, STAGGER=2; t0 is the first edge after RST falls.
REQ-031 Wake from reset: SLEEP_REQ=0, CH_EN=4'hF. SHALL see BUSY from t0, then GUARD bits 0/1/2/3 clearing at t0+3/+5/+7/+9, and AWAKE=1 at t0+10 with Q=D.
REQ-032 Sleep entry: from AWAKE, set SLEEP_REQ=1 at edge t. SHALL see at t GUARD=4'hF, Q=4'h0, SLEEP_ACK=1 and AWAKE=0.
REQ-033 Abort mid-release: assert SLEEP_REQ after GUARD=4'b1100. SHALL see at the next edge GUARD=4'hF and state ASLEEP, with no further releases.
REQ-034 Masked channels: CH_EN=4'b1010 with D=4'hF. SHALL see AWAKE at t0+10 with identical timing to REQ-031, and Q=4'b1010.
REQ-035 Async reset: pulse RST mid-RELEASE between clock edges. SHALL see GUARD=4'hF and Q=0 before the next CLK edge.
REQ-036 WAKE_CYCLES=0 variant: SLEEP_REQ=0 after reset. SHALL see GUARD[0] clear at t0, and AWAKE at t0+7.
